// File: rtl/hazard_pkg.sv
// Shared types, default latencies and counter helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    CauseNone   = 2'd0,
    CauseRaw    = 2'd1,
    CauseStruct = 2'd2,
    CauseBoth   = 2'd3
  } stall_cause_e;

  localparam int unsigned DefLoadLat = 1;
  localparam int unsigned DefMdLat   = 4;
  localparam int unsigned DefCntW    = 3;

  function automatic int unsigned sat_dec(int unsigned v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and hazard-response bundle between the decoder and the scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned PERF_W = 32
);
  localparam int unsigned RW = $clog2(NREG);

  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic [RW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_muldiv;
  logic          br_ctrl;

  logic                     load_stall;
  logic                     flush;
  hazard_pkg::stall_cause_e stall_cause;
  logic [PERF_W-1:0]        stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_mem_read, id_muldiv, br_ctrl,
    input  load_stall, flush, stall_cause, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_mem_read, id_muldiv, br_ctrl,
    output load_stall, flush, stall_cause, stall_cycles
  );
endinterface

// File: rtl/hazard_sb_cnt.sv
// One scoreboard entry: saturating down-counter that loads max(lat, decremented value).
module hazard_sb_cnt
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] lat_i,
  output logic             pending_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, dec;

  // Taking the max keeps a slower older writer (WAW) visible to later readers.
  always_comb begin
    dec   = CNT_W'(sat_dec(32'(cnt_q)));
    cnt_d = load_i ? CNT_W'(max_u(32'(lat_i), 32'(dec))) : dec;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pending_o = (cnt_q != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register result countdown, mul/div busy guard, flush and stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG     = 32,
  parameter int unsigned LOAD_LAT = DefLoadLat,
  parameter int unsigned MD_LAT   = DefMdLat,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned PERF_W   = 32
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave hz
);
  localparam int unsigned RW = $clog2(NREG);

  logic [NREG-1:0]   pending;
  logic              raw, structural, stall, issue, track;
  logic [CNT_W-1:0]  lat;
  logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  // x0 is hardwired, so it never holds a pending result.
  assign pending[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_sb
    hazard_sb_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i    (clk),
      .rst_i    (rst),
      .load_i   (track && (hz.id_rd == RW'(r))),
      .lat_i    (lat),
      .pending_o(pending[r])
    );
  end

  always_comb begin
    raw        = hz.id_valid & ((hz.id_rs1_used & pending[hz.id_rs1]) |
                                (hz.id_rs2_used & pending[hz.id_rs2]));
    structural = hz.id_valid & hz.id_muldiv & (md_cnt_q != '0);
    stall      = (raw | structural) & ~hz.br_ctrl;
    issue      = hz.id_valid & ~stall & ~hz.br_ctrl;
    // ALU results are forwarded, so only loads and mul/div occupy an entry.
    track      = issue & hz.id_reg_write & (hz.id_rd != '0) &
                 (hz.id_mem_read | hz.id_muldiv);
    lat        = hz.id_mem_read ? CNT_W'(LOAD_LAT) : CNT_W'(MD_LAT);
    md_cnt_d   = (issue & hz.id_muldiv) ? CNT_W'(MD_LAT) : CNT_W'(sat_dec(32'(md_cnt_q)));
    perf_d     = perf_q;
    if (stall && (perf_q != '1)) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt_q <= '0;
      perf_q   <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
      perf_q   <= perf_d;
    end
  end

  assign hz.load_stall   = stall;
  assign hz.flush        = hz.br_ctrl;
  assign hz.stall_cause  = stall_cause_e'({structural & stall, raw & stall});
  assign hz.stall_cycles = perf_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: stimulus pushes expected outputs per cycle, a negedge monitor pops and compares.
module tb_hazard_scoreboard;
  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       md;
    logic       br;
  } instr_t;

  typedef struct {
    bit          sel;
    logic        stall;
    logic        flush;
    logic [1:0]  cause;
    logic [31:0] perf;
    string       name;
  } exp_t;

  localparam instr_t Nop = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(32), .PERF_W(32)) ifa ();
  hazard_scoreboard_if #(.NREG(32), .PERF_W(2))  ifb ();

  hazard_scoreboard #(
    .NREG(32), .LOAD_LAT(1), .MD_LAT(4), .CNT_W(3), .PERF_W(32)
  ) u_dut_a (
    .clk(clk),
    .rst(rst),
    .hz (ifa)
  );

  hazard_scoreboard #(
    .NREG(32), .LOAD_LAT(2), .MD_LAT(4), .CNT_W(3), .PERF_W(2)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .hz (ifb)
  );

  exp_t        expq[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] perf_a   = '0;
  logic [1:0]  perf_b   = '0;

  function automatic instr_t alu(int rd, int rs1, int rs2);
    instr_t i = '0;
    i.valid = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
    i.u1 = 1'b1; i.u2 = 1'b1; i.we = 1'b1;
    return i;
  endfunction

  function automatic instr_t lw(int rd, int rs1);
    instr_t i = '0;
    i.valid = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.u1 = 1'b1; i.we = 1'b1; i.ld = 1'b1;
    return i;
  endfunction

  function automatic instr_t mul(int rd, int rs1, int rs2);
    instr_t i = alu(rd, rs1, rs2);
    i.md = 1'b1;
    return i;
  endfunction

  function automatic instr_t with_br(instr_t i);
    instr_t o = i;
    o.br = 1'b1;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One ID cycle on the selected DUT; the other DUT sees a bubble.
  task automatic step(input bit sel, input instr_t ins, input bit rst_v, input bit ex_stall,
                      input logic [1:0] ex_cause, input string name);
    exp_t   e;
    instr_t a, b;
    @(posedge clk);
    #1;
    a = sel ? Nop : ins;
    b = sel ? ins : Nop;
    rst = rst_v;
    ifa.id_valid = a.valid; ifa.id_rs1 = a.rs1; ifa.id_rs2 = a.rs2;
    ifa.id_rs1_used = a.u1; ifa.id_rs2_used = a.u2; ifa.id_rd = a.rd;
    ifa.id_reg_write = a.we; ifa.id_mem_read = a.ld; ifa.id_muldiv = a.md; ifa.br_ctrl = a.br;
    ifb.id_valid = b.valid; ifb.id_rs1 = b.rs1; ifb.id_rs2 = b.rs2;
    ifb.id_rs1_used = b.u1; ifb.id_rs2_used = b.u2; ifb.id_rd = b.rd;
    ifb.id_reg_write = b.we; ifb.id_mem_read = b.ld; ifb.id_muldiv = b.md; ifb.br_ctrl = b.br;
    e.sel = sel; e.stall = ex_stall; e.flush = ins.br; e.cause = ex_cause;
    e.perf = sel ? {30'd0, perf_b} : perf_a; e.name = name;
    expq.push_back(e);
    if (ex_stall) begin
      if (sel) begin
        if (perf_b != 2'b11) perf_b = perf_b + 2'd1;
      end else if (perf_a != 32'hffff_ffff) begin
        perf_a = perf_a + 32'd1;
      end
    end
    if (rst_v) begin
      perf_a = '0;
      perf_b = '0;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, Nop, 0, 0, 2'd0, "drain");
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t        e;
      logic [31:0] perf;
      logic        st, fl;
      logic [1:0]  ca;
      e    = expq.pop_front();
      st   = e.sel ? ifb.load_stall : ifa.load_stall;
      fl   = e.sel ? ifb.flush : ifa.flush;
      ca   = e.sel ? ifb.stall_cause : ifa.stall_cause;
      perf = e.sel ? {30'd0, ifb.stall_cycles} : ifa.stall_cycles;
      check({e.name, ".load_stall"}, {31'd0, st}, {31'd0, e.stall});
      check({e.name, ".flush"}, {31'd0, fl}, {31'd0, e.flush});
      check({e.name, ".stall_cause"}, {30'd0, ca}, {30'd0, e.cause});
      check({e.name, ".stall_cycles"}, perf, e.perf);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ifa.id_valid = 0; ifa.id_rs1 = 0; ifa.id_rs2 = 0; ifa.id_rs1_used = 0; ifa.id_rs2_used = 0;
    ifa.id_rd = 0; ifa.id_reg_write = 0; ifa.id_mem_read = 0; ifa.id_muldiv = 0; ifa.br_ctrl = 0;
    ifb.id_valid = 0; ifb.id_rs1 = 0; ifb.id_rs2 = 0; ifb.id_rs1_used = 0; ifb.id_rs2_used = 0;
    ifb.id_rd = 0; ifb.id_reg_write = 0; ifb.id_mem_read = 0; ifb.id_muldiv = 0; ifb.br_ctrl = 0;
    repeat (2) @(posedge clk);

    step(0, Nop, 1, 0, 2'd0, "reset");
    step(0, Nop, 0, 0, 2'd0, "idle");
    step(0, with_br(Nop), 0, 0, 2'd0, "flush_idle");

    // Classic load-use with LOAD_LAT=1.
    step(0, lw(5, 1), 0, 0, 2'd0, "t1_lw");
    step(0, alu(6, 5, 1), 0, 1, 2'd1, "t1_stall");
    step(0, alu(6, 5, 1), 0, 0, 2'd0, "t1_issue");
    step(0, Nop, 0, 0, 2'd0, "t1_count");
    drain(5);

    // mul result dependency.
    step(0, mul(7, 1, 2), 0, 0, 2'd0, "t3a_mul");
    for (int i = 0; i < 4; i++) step(0, alu(8, 7, 1), 0, 1, 2'd1, "t3a_stall");
    step(0, alu(8, 7, 1), 0, 0, 2'd0, "t3a_issue");
    drain(5);

    // Independent div behind mul: structural only.
    step(0, mul(7, 1, 2), 0, 0, 2'd0, "t3b_mul");
    for (int i = 0; i < 4; i++) step(0, mul(9, 1, 2), 0, 1, 2'd2, "t3b_struct");
    step(0, mul(9, 1, 2), 0, 0, 2'd0, "t3b_issue");
    drain(5);

    // Dependent div: both causes.
    step(0, mul(7, 1, 2), 0, 0, 2'd0, "t3c_mul");
    for (int i = 0; i < 4; i++) step(0, mul(10, 7, 1), 0, 1, 2'd3, "t3c_both");
    step(0, mul(10, 7, 1), 0, 0, 2'd0, "t3c_issue");
    drain(5);

    // Flush beats stall; killed load leaves x9 untracked; x7 keeps counting down.
    step(0, mul(7, 1, 2), 0, 0, 2'd0, "t4_mul");
    step(0, with_br(lw(9, 7)), 0, 0, 2'd0, "t4_flush");
    step(0, alu(10, 9, 9), 0, 0, 2'd0, "t4_no_x9");
    for (int i = 0; i < 2; i++) step(0, alu(11, 7, 1), 0, 1, 2'd1, "t4_x7_left");
    step(0, alu(11, 7, 1), 0, 0, 2'd0, "t4_issue");
    drain(5);

    // WAW: later load must not shorten the mul countdown.
    step(0, mul(5, 1, 2), 0, 0, 2'd0, "t5_mul");
    step(0, lw(5, 1), 0, 0, 2'd0, "t5_lw");
    for (int i = 0; i < 3; i++) step(0, alu(6, 5, 1), 0, 1, 2'd1, "t5_stall");
    step(0, alu(6, 5, 1), 0, 0, 2'd0, "t5_issue");
    drain(5);

    // Reset while stalled with sb[x5]=3.
    step(0, mul(5, 1, 2), 0, 0, 2'd0, "t6_mul");
    step(0, alu(6, 5, 1), 0, 1, 2'd1, "t6_stall4");
    step(0, alu(6, 5, 1), 1, 1, 2'd1, "t6_stall3_rst");
    step(0, alu(6, 5, 1), 0, 0, 2'd0, "t6_after_rst");
    drain(3);

    // LOAD_LAT=2 instance, 2-bit stall counter.
    step(1, lw(5, 1), 0, 0, 2'd0, "t2_lw");
    for (int i = 0; i < 2; i++) step(1, alu(6, 5, 1), 0, 1, 2'd1, "t2_stall");
    step(1, alu(6, 5, 1), 0, 0, 2'd0, "t2_issue");
    step(1, lw(0, 1), 0, 0, 2'd0, "t2_lw_x0");
    step(1, alu(6, 0, 0), 0, 0, 2'd0, "t2_x0_reader");
    for (int k = 0; k < 2; k++) begin
      step(1, lw(5, 1), 0, 0, 2'd0, "sat_lw");
      for (int i = 0; i < 2; i++) step(1, alu(6, 5, 1), 0, 1, 2'd1, "sat_stall");
      step(1, alu(6, 5, 1), 0, 0, 2'd0, "sat_issue");
    end
    step(1, Nop, 0, 0, 2'd0, "sat_final");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL queue_drain: %0d entries left, expected 0", expq.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
